life_respawn_ctrl: RTL and testbench
====================================

Name: life_respawn_ctrl

Overview:
- Sits directly downstream of the collision stage. It consumes the sticky mario_dead, luigi_dead and gomba_dead levels.
- Converts them into per-player life bookkeeping: a death animation hold, a respawn pulse with a blinking invulnerability window, and game-over detection. It also runs the goomba respawn timer.
- Issues collision_clear. The top level ORs collision_clear into the collision stage's Reset so the sticky flags drop after they have been consumed.

Parameters:
- LIVES, 3, starting lives per player (2-bit counter, 1..3).
- DEATH_FRAMES, 90, frames a player is frozen in death animation.
- INVULN_FRAMES, 120, frames of blinking invulnerability after respawn.
- GOMBA_FRAMES, 180, frames the goomba stays dead before respawn.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_Clk  in  1  vertical-sync frame clock, slow and asynchronous to Clk.
- mario_dead  in  1  sticky death level from collision.
- luigi_dead  in  1  sticky death level from collision.
- gomba_dead  in  1  sticky goomba death level from collision.
- mario_lives  out  2  remaining lives.
- luigi_lives  out  2  remaining lives.
- mario_freeze  out  1  block mario motion input (DYING/OUT).
- luigi_freeze  out  1  block luigi motion input.
- mario_visible  out  1  sprite enable for mario.
- luigi_visible  out  1  sprite enable for luigi.
- mario_respawn  out  1  one-Clk pulse: reload mario start position.
- luigi_respawn  out  1  one-Clk pulse: reload luigi start position.
- gomba_respawn  out  1  one-Clk pulse: reload goomba position.
- collision_clear  out  1  one-Clk pulse to clear collision flags.
- game_over  out  1  both players OUT.

Behaviour:
- Frame tick:
  - frame_Clk passes through a 2-flop synchronizer, then rising-edge detect.
  - frame_tick is a 1-Clk pulse, 3 Clk after the frame_Clk edge.
  - All frame counters advance only on frame_tick.
- Reset values:
  - Lives = LIVES.
  - Player FSMs = ALIVE; goomba FSM = G_ALIVE.
  - All counters = 0; mask = 0.
  - visible = 1, freeze = 0, all pulses = 0, game_over = 0.
  - Reset mid-operation aborts any state immediately. No pulse is emitted on the reset cycle.
- Player FSM (identical per player):
  - ALIVE:
    - If dead = 1 and mask = 0: go to DYING, lives -= 1, frame counter cleared.
    - visible = 1, freeze = 0.
  - DYING:
    - freeze = 1, visible = 1.
    - On frame_tick with cnt == DEATH_FRAMES-1:
      - If lives == 0: go to OUT.
      - Else: go to RESPAWN, pulse respawn and collision_clear in the same cycle.
  - RESPAWN:
    - freeze = 0; visible = cnt[2], toggling every 4 frames.
    - dead input ignored (invulnerable).
    - On frame_tick with cnt == INVULN_FRAMES-1: go to ALIVE, pulse collision_clear.
  - OUT:
    - freeze = 1, visible = 0, terminal until Reset.
  - Lives never wrap below 0. The decrement occurs only on the ALIVE→DYING transition.
- Goomba FSM:
  - G_ALIVE → G_DEAD when gomba_dead = 1 and mask = 0.
  - G_DEAD counts frames. On frame_tick with cnt == GOMBA_FRAMES-1: pulse gomba_respawn and collision_clear, return to G_ALIVE.
- collision_clear:
  - OR of all clear requests, registered.
  - Concurrent requests in one cycle produce a single pulse.
- Mask:
  - A 2-bit down counter, loaded with 2 on the cycle collision_clear is high.
  - While mask != 0, ALIVE/G_ALIVE ignore dead inputs. This covers the collision register's 1-cycle clear latency plus 1 cycle of margin.
  - A dead level sampled in the same cycle the pulse is issued is still accepted.
- Flag handling across clears:
  - A player already in DYING has its death latched. Clearing its flag via another source's clear is harmless.
  - If a dead flag is still high after RESPAWN→ALIVE plus mask expiry, the player dies again. This is intended (e.g. spawned onto the goomba).
- Simultaneous deaths: both players may enter DYING in the same cycle; each proceeds independently.
- game_over:
  - Registered; goes high the cycle after both FSMs are OUT.
  - Stays high until Reset.
- Counters:
  - 8-bit; parameters must be ≤ 255.
  - Compare uses an 8-bit cast of PARAM-1.

Decomposition:
- Shared package game_pkg:
  - player_state_t enum: ALIVE, DYING, RESPAWN, OUT.
  - gomba_state_t enum: G_ALIVE, G_DEAD.
  - localparam FRAME_CNT_W = 8.
- Natural sub-module player_life_fsm, instantiated twice (mario, luigi).
  - Inputs: Clk, Reset, frame_tick, dead, mask_active.
  - Outputs: lives, freeze, visible, respawn, clear_req, is_out.
  - Parameters pass through.
- Top-level life_respawn_ctrl holds the synchronizer, goomba FSM, clear OR/register, mask and game_over.

Test Plan:
- Setup: DEATH=4, INVULN=8, GOMBA=6; frame_Clk period 20 Clk.
- Mario death: mario_dead=1 for 1 cycle → mario_lives 3→2, freeze=1; after 4 frame ticks, mario_respawn and collision_clear high for exactly 1 Clk; visible toggles every 4 frames; after 8 frame ticks, back in ALIVE.
- Game over: three successive mario deaths → lives reach 0, mario in OUT, visible=0, freeze=1, no respawn pulse. Same for luigi → game_over=1 next cycle.
- Simultaneous deaths: mario_dead and luigi_dead high in the same cycle → both lives decrement; a single collision_clear pulse at the shared expiry (not two).
- Goomba respawn: gomba_dead=1 held → gomba_respawn pulse after 6 frame ticks. Hold gomba_dead high for 2 Clk after the clear → no re-trigger (mask). Hold it past mask expiry → re-enters G_DEAD.
- Reset during DYING: assert Reset at frame 2 of DYING → lives=3, visible=1, freeze=0, no pulses issued.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the life / respawn bookkeeping slice.
//   player_state_t : per-player life FSM states
//   gomba_state_t  : goomba respawn FSM states
//   FRAME_CNT_W    : width of every frame counter (parameters must be <= 255)
package game_pkg;

    localparam int FRAME_CNT_W = 8;
    localparam logic [FRAME_CNT_W-1:0] FRAME_CNT_ONE = FRAME_CNT_W'(1);

    typedef enum logic [1:0] {
        ALIVE,
        DYING,
        RESPAWN,
        OUT
    } player_state_t;

    typedef enum logic {
        G_ALIVE,
        G_DEAD
    } gomba_state_t;

    // Terminal count for a frame window of 'frames' frames.
    function automatic logic [FRAME_CNT_W-1:0] last_frame(input int frames);
        return FRAME_CNT_W'(frames - 1);
    endfunction

endpackage

// File: rtl/player_life_fsm.sv
// One player's life bookkeeping: death animation hold, respawn with a
// blinking invulnerability window, and lives / game-over tracking.
// Ports:
//   Clk, Reset    : system clock, synchronous active-high reset
//   frame_tick    : 1-Clk pulse per video frame; counters advance only on it
//   dead          : sticky death level from the collision stage
//   mask_active   : dead inputs are ignored while a collision clear settles
//   lives         : remaining lives
//   freeze        : block motion input (DYING / OUT)
//   visible       : sprite enable (blinks during RESPAWN, off when OUT)
//   respawn       : 1-Clk pulse to reload the start position
//   clear_req     : combinational request for a collision flag clear
//   is_out        : player has no lives left and has finished dying
module player_life_fsm
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int DEATH_FRAMES  = 90,
    parameter int INVULN_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       dead,
    input  logic       mask_active,
    output logic [1:0] lives,
    output logic       freeze,
    output logic       visible,
    output logic       respawn,
    output logic       clear_req,
    output logic       is_out
);

    player_state_t          state_q, state_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]             lives_q, lives_d;
    logic                   respawn_q, respawn_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lives_d   = lives_q;
        respawn_d = 1'b0;
        clear_req = 1'b0;
        freeze    = 1'b0;
        visible   = 1'b1;

        case (state_q)
            ALIVE: begin
                if (dead && !mask_active) begin
                    state_d = DYING;
                    cnt_d   = '0;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end
            end
            DYING: begin
                freeze = 1'b1;
                if (frame_tick) begin
                    if (cnt_q == last_frame(DEATH_FRAMES)) begin
                        cnt_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = OUT;
                        end else begin
                            state_d   = RESPAWN;
                            respawn_d = 1'b1;
                            clear_req = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + FRAME_CNT_ONE;
                    end
                end
            end
            RESPAWN: begin
                // Blink period of 8 frames; dead is ignored while invulnerable.
                visible = cnt_q[2];
                if (frame_tick) begin
                    if (cnt_q == last_frame(INVULN_FRAMES)) begin
                        state_d   = ALIVE;
                        cnt_d     = '0;
                        clear_req = 1'b1;
                    end else begin
                        cnt_d = cnt_q + FRAME_CNT_ONE;
                    end
                end
            end
            OUT: begin
                freeze  = 1'b1;
                visible = 1'b0;
            end
            default: state_d = ALIVE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ALIVE;
            cnt_q     <= '0;
            lives_q   <= 2'(LIVES);
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lives_q   <= lives_d;
            respawn_q <= respawn_d;
        end
    end

    assign lives   = lives_q;
    assign respawn = respawn_q;
    assign is_out  = (state_q == OUT);

endmodule

// File: rtl/life_respawn_ctrl.sv
// Life / respawn controller sitting after the collision stage.
// Turns the sticky death levels into per-player life bookkeeping, runs the
// goomba respawn timer and issues collision_clear (ORed into the collision
// stage reset by the top level) so consumed flags drop.
// Ports:
//   Clk, Reset                 : system clock, synchronous active-high reset
//   frame_Clk                  : vsync frame clock, asynchronous to Clk
//   mario/luigi/gomba_dead     : sticky death levels from collision
//   mario/luigi_lives          : remaining lives
//   mario/luigi_freeze         : block motion input
//   mario/luigi_visible        : sprite enables
//   mario/luigi/gomba_respawn  : 1-Clk position reload pulses
//   collision_clear            : 1-Clk collision flag clear pulse
//   game_over                  : both players out, held until Reset
module life_respawn_ctrl
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int DEATH_FRAMES  = 90,
    parameter int INVULN_FRAMES = 120,
    parameter int GOMBA_FRAMES  = 180
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_Clk,
    input  logic       mario_dead,
    input  logic       luigi_dead,
    input  logic       gomba_dead,
    output logic [1:0] mario_lives,
    output logic [1:0] luigi_lives,
    output logic       mario_freeze,
    output logic       luigi_freeze,
    output logic       mario_visible,
    output logic       luigi_visible,
    output logic       mario_respawn,
    output logic       luigi_respawn,
    output logic       gomba_respawn,
    output logic       collision_clear,
    output logic       game_over
);

    logic                   fsync1_q, fsync1_d;
    logic                   fsync2_q, fsync2_d;
    logic                   fsync3_q, fsync3_d;
    logic                   frame_tick_q, frame_tick_d;
    gomba_state_t           g_state_q, g_state_d;
    logic [FRAME_CNT_W-1:0] g_cnt_q, g_cnt_d;
    logic                   gomba_respawn_q, gomba_respawn_d;
    logic                   collision_clear_q, collision_clear_d;
    logic [1:0]             mask_q, mask_d;
    logic                   game_over_q, game_over_d;

    logic mask_active;
    logic mario_clear, luigi_clear, gomba_clear;
    logic mario_out, luigi_out;
    logic clear_any;

    assign mask_active = (mask_q != 2'd0);

    player_life_fsm #(
        .LIVES(LIVES), .DEATH_FRAMES(DEATH_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)
    ) u_mario (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick_q),
        .dead(mario_dead), .mask_active(mask_active),
        .lives(mario_lives), .freeze(mario_freeze), .visible(mario_visible),
        .respawn(mario_respawn), .clear_req(mario_clear), .is_out(mario_out)
    );

    player_life_fsm #(
        .LIVES(LIVES), .DEATH_FRAMES(DEATH_FRAMES), .INVULN_FRAMES(INVULN_FRAMES)
    ) u_luigi (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick_q),
        .dead(luigi_dead), .mask_active(mask_active),
        .lives(luigi_lives), .freeze(luigi_freeze), .visible(luigi_visible),
        .respawn(luigi_respawn), .clear_req(luigi_clear), .is_out(luigi_out)
    );

    always_comb begin
        // Two-flop synchronizer plus an edge-detect flop; the registered
        // tick lands 3 Clk after the frame_Clk edge.
        fsync1_d     = frame_Clk;
        fsync2_d     = fsync1_q;
        fsync3_d     = fsync2_q;
        frame_tick_d = fsync2_q & ~fsync3_q;

        g_state_d       = g_state_q;
        g_cnt_d         = g_cnt_q;
        gomba_respawn_d = 1'b0;
        gomba_clear     = 1'b0;

        case (g_state_q)
            G_ALIVE: begin
                if (gomba_dead && !mask_active) begin
                    g_state_d = G_DEAD;
                    g_cnt_d   = '0;
                end
            end
            G_DEAD: begin
                if (frame_tick_q) begin
                    if (g_cnt_q == last_frame(GOMBA_FRAMES)) begin
                        g_state_d       = G_ALIVE;
                        g_cnt_d         = '0;
                        gomba_respawn_d = 1'b1;
                        gomba_clear     = 1'b1;
                    end else begin
                        g_cnt_d = g_cnt_q + FRAME_CNT_ONE;
                    end
                end
            end
            default: g_state_d = G_ALIVE;
        endcase

        // Simultaneous requests collapse into one pulse.
        clear_any         = mario_clear | luigi_clear | gomba_clear;
        collision_clear_d = clear_any;

        // The mask loads alongside the clear pulse, so the dead levels seen
        // on the request edge still count, while the next two edges (flag
        // clear latency plus one cycle of margin) are ignored.
        if (clear_any)        mask_d = 2'd2;
        else if (mask_active) mask_d = mask_q - 2'd1;
        else                  mask_d = 2'd0;

        game_over_d = game_over_q | (mario_out & luigi_out);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync1_q          <= 1'b0;
            fsync2_q          <= 1'b0;
            fsync3_q          <= 1'b0;
            frame_tick_q      <= 1'b0;
            g_state_q         <= G_ALIVE;
            g_cnt_q           <= '0;
            gomba_respawn_q   <= 1'b0;
            collision_clear_q <= 1'b0;
            mask_q            <= 2'd0;
            game_over_q       <= 1'b0;
        end else begin
            fsync1_q          <= fsync1_d;
            fsync2_q          <= fsync2_d;
            fsync3_q          <= fsync3_d;
            frame_tick_q      <= frame_tick_d;
            g_state_q         <= g_state_d;
            g_cnt_q           <= g_cnt_d;
            gomba_respawn_q   <= gomba_respawn_d;
            collision_clear_q <= collision_clear_d;
            mask_q            <= mask_d;
            game_over_q       <= game_over_d;
        end
    end

    assign gomba_respawn   = gomba_respawn_q;
    assign collision_clear = collision_clear_q;
    assign game_over       = game_over_q;

endmodule

// File: tb/tb_life_respawn_ctrl.sv
// Randomized bench for life_respawn_ctrl against a frame-level reference
// model. The bench also plays the collision stage: dead flags are sticky and
// drop the edge after a collision_clear pulse predicted by the model.
module tb_life_respawn_ctrl;

    localparam int LIVES  = 3;
    localparam int DEATH  = 4;
    localparam int INVULN = 8;
    localparam int GOMBA  = 6;

    logic       Clk = 1'b0, Reset = 1'b1, frame_Clk = 1'b0;
    logic       mario_dead = 1'b0, luigi_dead = 1'b0, gomba_dead = 1'b0;
    logic [1:0] mario_lives, luigi_lives;
    logic       mario_freeze, luigi_freeze, mario_visible, luigi_visible;
    logic       mario_respawn, luigi_respawn, gomba_respawn;
    logic       collision_clear, game_over;

    life_respawn_ctrl #(
        .LIVES(LIVES), .DEATH_FRAMES(DEATH), .INVULN_FRAMES(INVULN), .GOMBA_FRAMES(GOMBA)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_Clk(frame_Clk),
        .mario_dead(mario_dead), .luigi_dead(luigi_dead), .gomba_dead(gomba_dead),
        .mario_lives(mario_lives), .luigi_lives(luigi_lives),
        .mario_freeze(mario_freeze), .luigi_freeze(luigi_freeze),
        .mario_visible(mario_visible), .luigi_visible(luigi_visible),
        .mario_respawn(mario_respawn), .luigi_respawn(luigi_respawn),
        .gomba_respawn(gomba_respawn), .collision_clear(collision_clear),
        .game_over(game_over)
    );

    initial forever #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 alive, 1 dying, 2 invulnerable, 3 out; el = frames elapsed in phase
    int ph[2], el[2], lv[2];
    bit rsp[2];
    int gph, gel;
    bit grsp, clr, go;
    bit fh[4];      // fh[i] = frame_Clk sampled i+1 edges ago
    bit clr_ev[2];  // clear events one and two edges ago

    task automatic model_step(input bit rst, input bit md, input bit ld,
                              input bit gd, input bit fk);
        bit tick, blocked, any, both_out;
        bit dd[2];
        dd[0] = md; dd[1] = ld;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                ph[p] = 0; el[p] = 0; lv[p] = LIVES; rsp[p] = 0;
            end
            gph = 0; gel = 0; grsp = 0; clr = 0; go = 0;
            for (int i = 0; i < 4; i++) fh[i] = 0;
            clr_ev[0] = 0; clr_ev[1] = 0;
            return;
        end
        tick     = fh[2] & ~fh[3];
        blocked  = clr_ev[0] | clr_ev[1];
        both_out = (ph[0] == 3) && (ph[1] == 3);
        any      = 0;
        for (int p = 0; p < 2; p++) begin
            rsp[p] = 0;
            if (ph[p] == 0) begin
                if (dd[p] && !blocked) begin
                    ph[p] = 1; el[p] = 0;
                    lv[p] = (lv[p] > 0) ? lv[p] - 1 : 0;
                end
            end else if (ph[p] == 1 && tick) begin
                el[p]++;
                if (el[p] == DEATH) begin
                    el[p] = 0;
                    if (lv[p] == 0) ph[p] = 3;
                    else begin ph[p] = 2; rsp[p] = 1; any = 1; end
                end
            end else if (ph[p] == 2 && tick) begin
                el[p]++;
                if (el[p] == INVULN) begin ph[p] = 0; el[p] = 0; any = 1; end
            end
        end
        grsp = 0;
        if (gph == 0) begin
            if (gd && !blocked) begin gph = 1; gel = 0; end
        end else if (tick) begin
            gel++;
            if (gel == GOMBA) begin gph = 0; gel = 0; grsp = 1; any = 1; end
        end
        clr = any;
        go  = go | both_out;
        clr_ev[1] = clr_ev[0]; clr_ev[0] = any;
        fh[3] = fh[2]; fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = fk;
    endtask

    function automatic int exp_vis(input int p);
        if (ph[p] == 2) return (el[p] / 4) % 2;
        return (ph[p] == 3) ? 0 : 1;
    endfunction

    function automatic int exp_frz(input int p);
        return (ph[p] == 1 || ph[p] == 3) ? 1 : 0;
    endfunction

    // ---------------- cycle driver ----------------
    int cyc = 0;
    bit clr_prev = 0;
    bit g_hold = 0;
    bit m_flag = 0, l_flag = 0, g_flag = 0;

    task automatic cycle();
        @(posedge Clk);
        model_step(Reset, mario_dead, luigi_dead, gomba_dead, frame_Clk);
        #1;
        chk("mario_lives",     mario_lives,     lv[0]);
        chk("luigi_lives",     luigi_lives,     lv[1]);
        chk("mario_freeze",    mario_freeze,    exp_frz(0));
        chk("luigi_freeze",    luigi_freeze,    exp_frz(1));
        chk("mario_visible",   mario_visible,   exp_vis(0));
        chk("luigi_visible",   luigi_visible,   exp_vis(1));
        chk("mario_respawn",   mario_respawn,   rsp[0]);
        chk("luigi_respawn",   luigi_respawn,   rsp[1]);
        chk("gomba_respawn",   gomba_respawn,   grsp);
        chk("collision_clear", collision_clear, clr);
        chk("game_over",       game_over,       go);
        cyc++;
        if (cyc % 10 == 0) frame_Clk = ~frame_Clk;
        // Collision flags are reset by the pulse seen on the previous edge.
        if (clr_prev || Reset) begin m_flag = 0; l_flag = 0; g_flag = 0; end
        clr_prev = clr;
    endtask

    task automatic drive();
        mario_dead = m_flag;
        luigi_dead = l_flag;
        gomba_dead = g_flag | g_hold;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1; m_flag = 0; l_flag = 0; g_flag = 0; g_hold = 0; drive();
        repeat (n) cycle();
        Reset = 1'b0;
    endtask

    task automatic random_run(input int n, input int rng);
        repeat (n) begin
            cycle();
            if ($urandom_range(0, rng) == 0) m_flag = 1;
            if ($urandom_range(0, rng) == 0) l_flag = 1;
            if ($urandom_range(0, rng) == 0) g_flag = 1;
            drive();
        end
    endtask

    initial begin
        bit reached;
        int guard;

        // Reset state
        do_reset(3);

        // Sparse random deaths
        random_run(2500, 150);

        // Dense deaths until both players are out, then check it sticks
        do_reset(2);
        guard = 0;
        while (!go && guard < 6000) begin
            random_run(1, 15);
            guard++;
        end
        random_run(40, 15);
        chk("game_over_reached", game_over, 1);

        // Simultaneous deaths: one shared clear pulse at the common expiry
        do_reset(2);
        m_flag = 1; l_flag = 1; drive();
        repeat (400) begin cycle(); drive(); end

        // Reset during the third frame of DYING
        do_reset(2);
        m_flag = 1; drive();
        reached = 0;
        guard   = 0;
        while (!reached && guard < 600) begin
            cycle(); drive();
            reached = (ph[0] == 1) && (el[0] == 2);
            guard++;
        end
        chk("dying_frame2_reached", reached, 1);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0; m_flag = 0; drive();
        chk("rst_mid_lives", mario_lives, LIVES);
        chk("rst_mid_visible", mario_visible, 1);
        chk("rst_mid_freeze", mario_freeze, 0);
        repeat (200) begin cycle(); drive(); end

        // Goomba dead held high: respawn, masked for two edges, then re-dies
        do_reset(2);
        g_hold = 1; drive();
        repeat (700) begin cycle(); drive(); end
        g_hold = 0; drive();
        random_run(300, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
